// File: rtl/npu_instgen.sv
// Layer-level instruction generator: latches a layer descriptor, splits output
// channels into PE_NUM-wide groups and issues one decoder instruction per group.
module npu_instgen #(
  parameter int PE_NUM  = 16,
  parameter int DATA_W  = 16,
  parameter int FRAM_AW = 16,
  parameter int KRAM_AW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAM_AW-1:0] cfg_feature_baseaddr,
  input  logic [KRAM_AW-1:0] cfg_kernel_baseaddr,
  input  logic [DATA_W-1:0]  cfg_chin,
  input  logic [DATA_W-1:0]  cfg_chout,
  input  logic [DATA_W-1:0]  cfg_width,
  input  logic [DATA_W-1:0]  cfg_height,
  input  logic [7:0]         cfg_kh,
  input  logic [7:0]         cfg_kw,
  input  logic               cfg_has_bias,
  input  logic               cfg_has_relu,
  input  logic [FRAM_AW-1:0] cfg_wb_baseaddr,
  input  logic [DATA_W-1:0]  cfg_wb_ch_offset,
  output logic [FRAM_AW-1:0] feature_baseaddr,
  output logic [KRAM_AW-1:0] kernel_baseaddr,
  output logic [DATA_W-1:0]  feature_chin,
  output logic [DATA_W-1:0]  feature_chout,
  output logic [DATA_W-1:0]  feature_width,
  output logic [DATA_W-1:0]  feature_height,
  output logic [7:0]         kernel_sizeh,
  output logic [7:0]         kernel_sizew,
  output logic               has_bias,
  output logic               has_relu,
  output logic [FRAM_AW-1:0] wb_baseaddr,
  output logic [DATA_W-1:0]  wb_ch_offset,
  output logic [DATA_W-1:0]  valid_pe_num,
  output logic               inst_valid,
  output logic               tlast,
  input  logic               decoder_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

  localparam logic [DATA_W-1:0] PE_W = DATA_W'(PE_NUM);

  state_t state_q, state_d;

  logic [FRAM_AW-1:0] fbase_q, fbase_d, wbase_q, wbase_d, waddr_q, waddr_d, wstride_q, wstride_d;
  logic [KRAM_AW-1:0] kbase_q, kbase_d, kaddr_q, kaddr_d, kstride_q, kstride_d;
  logic [DATA_W-1:0]  chin_q, chin_d, chout_q, chout_d, width_q, width_d;
  logic [DATA_W-1:0]  height_q, height_d, wofs_q, wofs_d, rem_q, rem_d;
  logic [7:0]         kh_q, kh_d, kw_q, kw_d;
  logic               bias_q, bias_d, relu_q, relu_d;

  logic last_grp;
  logic xfer;

  assign last_grp = (rem_q <= PE_W);
  assign xfer     = (state_q == ISSUE) && decoder_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    state_d = (chout_q == '0) ? DONE : ISSUE;
      ISSUE:   if (xfer && last_grp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    inst_valid    = (state_q == ISSUE);
    done          = (state_q == DONE);
    tlast         = (state_q == ISSUE) && last_grp;
    feature_chout = (rem_q > PE_W) ? PE_W : rem_q;
    valid_pe_num  = feature_chout;
  end

  assign feature_baseaddr = fbase_q;
  assign kernel_baseaddr  = kaddr_q;
  assign feature_chin     = chin_q;
  assign feature_width    = width_q;
  assign feature_height   = height_q;
  assign kernel_sizeh     = kh_q;
  assign kernel_sizew     = kw_q;
  assign has_bias         = bias_q;
  assign has_relu         = relu_q;
  assign wb_baseaddr      = waddr_q;
  assign wb_ch_offset     = wofs_q;

  // Strides are computed in the address width so truncation falls out of the arithmetic.
  always_comb begin
    fbase_d = fbase_q;  kbase_d = kbase_q;  wbase_d = wbase_q;
    chin_d = chin_q;    chout_d = chout_q;  width_d = width_q;
    height_d = height_q; kh_d = kh_q;       kw_d = kw_q;
    bias_d = bias_q;    relu_d = relu_q;    wofs_d = wofs_q;
    kstride_d = kstride_q; wstride_d = wstride_q;
    rem_d = rem_q;      kaddr_d = kaddr_q;  waddr_d = waddr_q;
    case (state_q)
      IDLE: if (start) begin
        fbase_d  = cfg_feature_baseaddr;
        kbase_d  = cfg_kernel_baseaddr;
        wbase_d  = cfg_wb_baseaddr;
        chin_d   = cfg_chin;
        chout_d  = cfg_chout;
        width_d  = cfg_width;
        height_d = cfg_height;
        kh_d     = cfg_kh;
        kw_d     = cfg_kw;
        bias_d   = cfg_has_bias;
        relu_d   = cfg_has_relu;
        wofs_d   = cfg_wb_ch_offset;
      end
      CALC: begin
        kstride_d = KRAM_AW'(PE_NUM) * KRAM_AW'(chin_q) * KRAM_AW'(kh_q) * KRAM_AW'(kw_q);
        wstride_d = FRAM_AW'(PE_NUM) * FRAM_AW'(wofs_q);
        rem_d     = chout_q;
        kaddr_d   = kbase_q;
        waddr_d   = wbase_q;
      end
      ISSUE: if (xfer && !last_grp) begin
        rem_d   = rem_q - PE_W;
        kaddr_d = kaddr_q + kstride_q;
        waddr_d = waddr_q + wstride_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbase_q <= '0;  kbase_q <= '0;  wbase_q <= '0;
      chin_q <= '0;   chout_q <= '0;  width_q <= '0;
      height_q <= '0; kh_q <= '0;     kw_q <= '0;
      bias_q <= 1'b0; relu_q <= 1'b0; wofs_q <= '0;
      kstride_q <= '0; wstride_q <= '0;
      rem_q <= '0;    kaddr_q <= '0;  waddr_q <= '0;
    end else begin
      fbase_q <= fbase_d;  kbase_q <= kbase_d;  wbase_q <= wbase_d;
      chin_q <= chin_d;    chout_q <= chout_d;  width_q <= width_d;
      height_q <= height_d; kh_q <= kh_d;       kw_q <= kw_d;
      bias_q <= bias_d;    relu_q <= relu_d;    wofs_q <= wofs_d;
      kstride_q <= kstride_d; wstride_q <= wstride_d;
      rem_q <= rem_d;      kaddr_q <= kaddr_d;  waddr_q <= waddr_d;
    end
  end

endmodule

// File: tb/tb_npu_instgen.sv
// Randomized bench for npu_instgen; expected instruction stream is derived
// per layer from the descriptor with plain arithmetic.
module tb_npu_instgen;
  localparam int PE = 16;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, decoder_ready = 1'b0;
  logic [15:0] cfg_feature_baseaddr = '0, cfg_kernel_baseaddr = '0, cfg_chin = '0, cfg_chout = '0;
  logic [15:0] cfg_width = '0, cfg_height = '0, cfg_wb_baseaddr = '0, cfg_wb_ch_offset = '0;
  logic [7:0]  cfg_kh = '0, cfg_kw = '0;
  logic        cfg_has_bias = 1'b0, cfg_has_relu = 1'b0;
  logic [15:0] feature_baseaddr, kernel_baseaddr, feature_chin, feature_chout, feature_width;
  logic [15:0] feature_height, wb_baseaddr, wb_ch_offset, valid_pe_num;
  logic [7:0]  kernel_sizeh, kernel_sizew;
  logic        has_bias, has_relu, inst_valid, tlast, busy, done;

  typedef struct {
    logic [15:0] fbase, kbase, chin, chout, w, h, wbase, wofs;
    logic [7:0]  kh, kw;
    logic        bias, relu;
  } cfg_t;

  int n_tests = 0;
  int n_fail  = 0;

  npu_instgen #(.PE_NUM(PE), .DATA_W(16), .FRAM_AW(16), .KRAM_AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_feature_baseaddr(cfg_feature_baseaddr), .cfg_kernel_baseaddr(cfg_kernel_baseaddr),
    .cfg_chin(cfg_chin), .cfg_chout(cfg_chout), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_kh(cfg_kh), .cfg_kw(cfg_kw), .cfg_has_bias(cfg_has_bias), .cfg_has_relu(cfg_has_relu),
    .cfg_wb_baseaddr(cfg_wb_baseaddr), .cfg_wb_ch_offset(cfg_wb_ch_offset),
    .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
    .feature_chin(feature_chin), .feature_chout(feature_chout), .feature_width(feature_width),
    .feature_height(feature_height), .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew),
    .has_bias(has_bias), .has_relu(has_relu), .wb_baseaddr(wb_baseaddr),
    .wb_ch_offset(wb_ch_offset), .valid_pe_num(valid_pe_num), .inst_valid(inst_valid),
    .tlast(tlast), .decoder_ready(decoder_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_feature_baseaddr = c.fbase; cfg_kernel_baseaddr = c.kbase;
    cfg_chin = c.chin; cfg_chout = c.chout; cfg_width = c.w; cfg_height = c.h;
    cfg_kh = c.kh; cfg_kw = c.kw; cfg_has_bias = c.bias; cfg_has_relu = c.relu;
    cfg_wb_baseaddr = c.wbase; cfg_wb_ch_offset = c.wofs;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.fbase = 16'($urandom); c.kbase = 16'($urandom); c.chin = 16'($urandom_range(1, 600));
    c.chout = 16'($urandom_range(0, 80)); c.w = 16'($urandom); c.h = 16'($urandom);
    c.kh = 8'($urandom_range(1, 7)); c.kw = 8'($urandom_range(1, 7));
    c.bias = 1'($urandom); c.relu = 1'($urandom);
    c.wbase = 16'($urandom); c.wofs = 16'($urandom);
    return c;
  endfunction

  // mode 0: always ready, 1: random ready, 2: ready low 5 cycles per instruction.
  // poke: pulse start with a different descriptor while the layer is issuing.
  task automatic run_layer(input cfg_t c, input int mode, input bit poke);
    int n, g, done_cyc, hold, cyc;
    bit exp_valid, finished;
    longint rem, ch, kexp, wexp;
    cfg_t other;
    n = (int'(c.chout) + PE - 1) / PE;
    g = 0; hold = 0; finished = 0;
    done_cyc = (n == 0) ? 2 : -1;
    @(negedge clk);
    drive_cfg(c);
    start = 1'b1;
    decoder_ready = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    drive_cfg(rand_cfg());
    for (cyc = 1; cyc < 2000; cyc++) begin
      exp_valid = (cyc >= 2) && (g < n);
      chk("inst_valid", inst_valid, exp_valid);
      chk("done", done, cyc == done_cyc);
      chk("busy", busy, (done_cyc < 0) || (cyc <= done_cyc));
      if (exp_valid) begin
        rem  = longint'(c.chout) - longint'(g) * PE;
        ch   = (rem > PE) ? PE : rem;
        kexp = (longint'(c.kbase) + longint'(g) * PE * longint'(c.chin) * longint'(c.kh) * longint'(c.kw)) % 65536;
        wexp = (longint'(c.wbase) + longint'(g) * PE * longint'(c.wofs)) % 65536;
        chk("feature_chout", feature_chout, ch);
        chk("valid_pe_num", valid_pe_num, ch);
        chk("kernel_baseaddr", kernel_baseaddr, kexp);
        chk("wb_baseaddr", wb_baseaddr, wexp);
        chk("tlast", tlast, g == n - 1);
        chk("feature_baseaddr", feature_baseaddr, c.fbase);
        chk("feature_chin", feature_chin, c.chin);
        chk("geometry", {feature_width, feature_height, kernel_sizeh, kernel_sizew},
            {c.w, c.h, c.kh, c.kw});
        chk("flags_ofs", {has_bias, has_relu, wb_ch_offset}, {c.bias, c.relu, c.wofs});
      end else begin
        chk("tlast_idle", tlast, 1'b0);
      end
      if (done_cyc >= 0 && cyc > done_cyc) begin
        finished = 1;
        break;
      end
      start = 1'b0;
      if (poke && cyc == 3) begin
        other = rand_cfg();
        other.chout = 16'd64;
        drive_cfg(other);
        start = 1'b1;
      end
      if (exp_valid) begin
        case (mode)
          0: decoder_ready = 1'b1;
          1: decoder_ready = 1'($urandom);
          default: begin
            decoder_ready = (hold == 5);
            hold = decoder_ready ? 0 : hold + 1;
          end
        endcase
        if (decoder_ready) begin
          if (g == n - 1) done_cyc = cyc + 1;
          g++;
        end
      end else begin
        decoder_ready = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("layer_completed", finished, 1'b1);
    chk("groups_issued", g, n);
  endtask

  initial begin
    cfg_t c;
    repeat (3) @(negedge clk);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_valid_pe_num", valid_pe_num, 0);
    chk("rst_kernel_baseaddr", kernel_baseaddr, 0);
    rst_n = 1'b1;

    // Two full groups, continuous ready.
    c = '{fbase: 16'd0, kbase: 16'd0, chin: 16'd3, chout: 16'd32, w: 16'd200, h: 16'd100,
          wbase: 16'd0, wofs: 16'd20000, kh: 8'd3, kw: 8'd3, bias: 1'b1, relu: 1'b1};
    run_layer(c, 0, 0);
    // Partial last group.
    c.chout = 16'd20; c.kbase = 16'd100;
    run_layer(c, 0, 0);
    // Backpressure on each instruction.
    c.chout = 16'd32; c.kbase = 16'd7;
    run_layer(c, 2, 0);
    // Start while busy must be ignored.
    run_layer(c, 2, 1);
    // Empty layer.
    c.chout = 16'd0;
    run_layer(c, 1, 0);

    // Reset while an instruction is pending.
    c = rand_cfg();
    c.chout = 16'd16;
    @(negedge clk);
    drive_cfg(c); start = 1'b1; decoder_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_inst_valid", inst_valid, 1'b1);
    chk("pre_rst_tlast", tlast, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_inst_valid", inst_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_tlast", tlast, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    c = rand_cfg();
    c.chout = 16'd16;
    run_layer(c, 1, 0);

    for (int i = 0; i < 25; i++) begin
      c = rand_cfg();
      run_layer(c, int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
